// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor SCAN elevator controller; latches cab/hall requests, moves the car, sequences the door, optional BCD-PIN login gate.
// Latency: request at the idle car's floor opens the door 2 cycles later; one floor away takes TRAVEL_CYCLES+2 cycles.
// Backpressure: none; requests are level/pulse inputs ORed into a latch. Define MGMT_LOCK_EN to latch requests only while logged in.
module elevator_scan_ctrl #(
    parameter int          FLOORS        = 8,
    parameter int          FLOOR_W       = 3,
    parameter int          TRAVEL_CYCLES = 8,
    parameter int          DOOR_CYCLES   = 4,
    parameter logic [15:0] PIN           = 16'h1234
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [3:0]         bcd_digit,
    input  logic               bcd_valid,
    input  logic [FLOORS-1:0]  cab_req,
    input  logic [FLOORS-1:0]  hall_req,
    output logic [1:0]         engine,
    output logic               door_open,
    output logic [FLOOR_W-1:0] floor,
    output logic [FLOORS-1:0]  pending,
    output logic               logged_in
);
    localparam int TT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TT_W-1:0] TRAVEL_LAST = TT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DT_W-1:0] DOOR_LAST   = DT_W'(DOOR_CYCLES - 1);
    localparam logic [1:0] ENG_STOP = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b01;
    localparam logic [1:0] ENG_DOWN = 2'b10;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t             state;
    logic               dir_up;
    logic [TT_W-1:0]    travel_tmr;
    logic [DT_W-1:0]    door_tmr;

    logic [FLOORS-1:0]  req_in;
    logic [FLOORS-1:0]  eff;
    logic [FLOORS-1:0]  clr;
    logic [FLOOR_W-1:0] next_floor;
    logic               travel_done;
    logic               door_done;
    logic               arrive_stop;
    logic               eff_beyond;
    logic               req_above;
    logic               req_below;

    function automatic logic [FLOORS-1:0] floors_above(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] floors_below(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        m    = '0;
        m[f] = 1'b1;
        return m;
    endfunction

    // Request gating, arrival lookahead and the pending bit cleared this cycle.
    always_comb begin
        req_in      = (cab_req | hall_req) & {FLOORS{logged_in}};
        eff         = pending | req_in;
        travel_done = (travel_tmr == TRAVEL_LAST);
        door_done   = (door_tmr == DOOR_LAST);
        req_above   = |(pending & floors_above(floor));
        req_below   = |(pending & floors_below(floor));
        next_floor  = floor;
        case (state)
            MOVE_UP:   next_floor = floor + FLOOR_W'(1);
            MOVE_DOWN: next_floor = floor - FLOOR_W'(1);
            default:   next_floor = floor;
        endcase
        // Arrival sees requests landing on the same edge so they are served by this stop.
        arrive_stop = eff[next_floor];
        eff_beyond  = (state == MOVE_UP) ? |(eff & floors_above(next_floor))
                                         : |(eff & floors_below(next_floor));
        clr = '0;
        case (state)
            IDLE:              if (pending[floor]) clr = floor_bit(floor);
            MOVE_UP, MOVE_DOWN: if (travel_done && arrive_stop) clr = floor_bit(next_floor);
            DOOR:              clr = floor_bit(floor);
            default:           clr = '0;
        endcase
    end

    // Main SCAN FSM: request latch, motion, door timing, all outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            dir_up     <= 1'b1;
            floor      <= '0;
            engine     <= ENG_STOP;
            door_open  <= 1'b0;
            pending    <= '0;
            travel_tmr <= '0;
            door_tmr   <= '0;
        end else begin
            pending <= eff & ~clr;
            case (state)
                IDLE: begin
                    if (pending[floor]) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        door_tmr  <= '0;
                    end else if (req_above && (dir_up || !req_below)) begin
                        state      <= MOVE_UP;
                        dir_up     <= 1'b1;
                        engine     <= ENG_UP;
                        travel_tmr <= '0;
                    end else if (req_below) begin
                        state      <= MOVE_DOWN;
                        dir_up     <= 1'b0;
                        engine     <= ENG_DOWN;
                        travel_tmr <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (!travel_done) begin
                        travel_tmr <= travel_tmr + TT_W'(1);
                    end else begin
                        floor      <= next_floor;
                        travel_tmr <= '0;
                        if (arrive_stop) begin
                            state     <= DOOR;
                            engine    <= ENG_STOP;
                            door_open <= 1'b1;
                            door_tmr  <= '0;
                        end else if (!eff_beyond) begin
                            // Nothing further this way; IDLE picks the next direction.
                            state  <= IDLE;
                            engine <= ENG_STOP;
                        end
                    end
                end
                DOOR: begin
                    if (req_in[floor]) begin
                        door_tmr <= '0;
                    end else if (door_done) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        door_tmr  <= '0;
                    end else begin
                        door_tmr <= door_tmr + DT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MGMT_LOCK_EN
    logic [1:0] pin_idx;
    logic [3:0] pin_digit;

    // Expected PIN digit for the current position, most significant first.
    always_comb begin
        case (pin_idx)
            2'd0: pin_digit = PIN[15:12];
            2'd1: pin_digit = PIN[11:8];
            2'd2: pin_digit = PIN[7:4];
            2'd3: pin_digit = PIN[3:0];
        endcase
    end

    // Login sequencer: F always logs out; digits are ignored while logged in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            logged_in <= 1'b0;
            pin_idx   <= 2'd0;
        end else if (bcd_valid) begin
            if (bcd_digit == 4'hF) begin
                logged_in <= 1'b0;
                pin_idx   <= 2'd0;
            end else if (!logged_in) begin
                if (bcd_digit == pin_digit) begin
                    if (pin_idx == 2'd3) begin
                        logged_in <= 1'b1;
                        pin_idx   <= 2'd0;
                    end else begin
                        pin_idx <= pin_idx + 2'd1;
                    end
                end else begin
                    // A wrong digit may itself start a new attempt.
                    pin_idx <= (bcd_digit == PIN[15:12]) ? 2'd1 : 2'd0;
                end
            end
        end
    end
`else
    logic unused_bcd;
    assign unused_bcd = ^{bcd_digit, bcd_valid};
    assign logged_in  = 1'b1;
`endif

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios then random requests/keypad traffic,
// every cycle compared against a behavioural model kept in remaining-cycle counts and int floors.
// Build with or without MGMT_LOCK_EN; login scenarios are only compiled in when it is defined.
module tb_elevator_scan_ctrl;
    localparam int FLOORS = 8;
    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;
`ifdef MGMT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] bcd_digit;
    logic       bcd_valid;
    logic [7:0] cab_req;
    logic [7:0] hall_req;
    logic [1:0] engine;
    logic       door_open;
    logic [2:0] floor;
    logic [7:0] pending;
    logic       logged_in;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         m_floor;
    bit         m_up, m_moving, m_door, m_login;
    int         m_travel_left, m_door_left, m_pin_pos;
    logic [7:0] m_pend;
    int         pin_d[4] = '{1, 2, 3, 4};

    elevator_scan_ctrl #(
        .FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR), .PIN(16'h1234)
    ) dut (
        .CLK(CLK), .RST(RST), .bcd_digit(bcd_digit), .bcd_valid(bcd_valid),
        .cab_req(cab_req), .hall_req(hall_req), .engine(engine), .door_open(door_open),
        .floor(floor), .pending(pending), .logged_in(logged_in)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    function automatic bit any_beyond(input logic [7:0] p, input int f, input bit up);
        for (int i = 0; i < FLOORS; i++)
            if (p[i] && ((up && i > f) || (!up && i < f))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_up = 1'b1; m_moving = 1'b0; m_door = 1'b0;
        m_travel_left = 0; m_door_left = 0; m_pin_pos = 0;
        m_pend = '0; m_login = !LOCK;
    endtask

    // One clock of the specification's rules, using the inputs present at the edge.
    task automatic model_clock();
        logic [7:0] req, all;
        bit want_up, want_dn;
        req = (cab_req | hall_req) & {8{m_login}};
        if (m_door) begin
            if (req[m_floor]) m_door_left = DOOR;
            else begin
                m_door_left--;
                if (m_door_left == 0) m_door = 1'b0;
            end
            req[m_floor] = 1'b0;
            m_pend |= req;
        end else if (m_moving) begin
            m_travel_left--;
            if (m_travel_left == 0) begin
                m_floor = m_up ? m_floor + 1 : m_floor - 1;
                all = m_pend | req;
                if (all[m_floor]) begin
                    m_moving = 1'b0; m_door = 1'b1; m_door_left = DOOR;
                    all[m_floor] = 1'b0;
                end else if (!any_beyond(all, m_floor, m_up)) m_moving = 1'b0;
                else m_travel_left = TRAVEL;
                m_pend = all;
            end else m_pend |= req;
        end else begin
            if (m_pend[m_floor]) begin
                m_door = 1'b1; m_door_left = DOOR;
                m_pend = (m_pend | req) & ~(8'b1 << m_floor);
            end else begin
                want_up = any_beyond(m_pend, m_floor, 1'b1);
                want_dn = any_beyond(m_pend, m_floor, 1'b0);
                if (want_up && !want_dn) m_up = 1'b1;
                else if (want_dn && !want_up) m_up = 1'b0;
                if (want_up || want_dn) begin m_moving = 1'b1; m_travel_left = TRAVEL; end
                m_pend |= req;
            end
        end
        if (LOCK && bcd_valid) begin
            if (bcd_digit == 4'hF) begin m_login = 1'b0; m_pin_pos = 0; end
            else if (!m_login) begin
                if (int'(bcd_digit) == pin_d[m_pin_pos]) begin
                    m_pin_pos++;
                    if (m_pin_pos == 4) begin m_login = 1'b1; m_pin_pos = 0; end
                end else m_pin_pos = (int'(bcd_digit) == pin_d[0]) ? 1 : 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] e_eng;
        e_eng = m_moving ? (m_up ? 2'b01 : 2'b10) : 2'b00;
        check("engine", 32'(engine), 32'(e_eng));
        check("door_open", 32'(door_open), 32'(m_door));
        check("floor", 32'(floor), 32'(m_floor));
        check("pending", 32'(pending), 32'(m_pend));
        check("logged_in", 32'(logged_in), 32'(m_login));
    endtask

    task automatic step();
        @(posedge CLK);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic pulse(input bit hall, input int f);
        if (hall) hall_req = 8'b1 << f;
        else      cab_req  = 8'b1 << f;
        step();
        cab_req = '0; hall_req = '0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        bcd_digit = d; bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
    endtask

    task automatic wait_door(input string tag, input int budget);
        int n;
        n = 0;
        while (!door_open && n < budget) begin step(); n++; end
        check(tag, 32'(door_open), 32'd1);
    endtask

    initial begin
        RST = 1'b1; bcd_digit = '0; bcd_valid = 1'b0; cab_req = '0; hall_req = '0;
        model_reset();
        #7;
        check_all();
        check("rst_engine", 32'(engine), 32'd0);
        check("rst_floor", 32'(floor), 32'd0);
`ifdef MGMT_LOCK_EN
        check("rst_login", 32'(logged_in), 32'd0);
`else
        check("rst_login", 32'(logged_in), 32'd1);
`endif
        RST = 1'b0;

`ifdef MGMT_LOCK_EN
        // Locked: requests ignored
        pulse(1'b0, 5);
        repeat (3) step();
        check("lock_pending", 32'(pending), 32'd0);
        check("lock_engine", 32'(engine), 32'd0);
        send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
        check("pin_login", 32'(logged_in), 32'd1);
        send_digit(4'd1); send_digit(4'd2); send_digit(4'd9);
        check("pin_ignored", 32'(logged_in), 32'd1);
        send_digit(4'hF);
        check("pin_logout", 32'(logged_in), 32'd0);
        send_digit(4'd1); send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
        check("pin_relogin", 32'(logged_in), 32'd1);
`endif

        // Floor 0 -> 5
        pulse(1'b0, 5);
        check("s1_latch", 32'(pending), 32'h20);
        step();
        check("s1_engine", 32'(engine), 32'd1);
        repeat (5 * TRAVEL - 1) step();
        check("s1_floor4", 32'(floor), 32'd4);
        step();
        check("s1_floor5", 32'(floor), 32'd5);
        check("s1_door", 32'(door_open), 32'd1);
        check("s1_pending", 32'(pending), 32'd0);
        repeat (DOOR - 1) step();
        check("s1_door_held", 32'(door_open), 32'd1);
        step();
        check("s1_door_shut", 32'(door_open), 32'd0);

        // Request at current idle floor: door after two cycles
        pulse(1'b1, 5);
        check("s2_lat1", 32'(door_open), 32'd0);
        step();
        check("s2_lat2", 32'(door_open), 32'd1);
        repeat (DOOR) step();
        check("s2_shut", 32'(door_open), 32'd0);

        // Door restart at floor 2
        pulse(1'b0, 2);
        wait_door("s3_arrive", 3 * TRAVEL + 4);
        check("s3_floor", 32'(floor), 32'd2);
        step(); step();
        cab_req = 8'h04;
        step();
        cab_req = '0;
        check("s3_hold0", 32'(door_open), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("s3_hold", 32'(door_open), 32'd1);
        end
        step();
        check("s3_close", 32'(door_open), 32'd0);

        // One floor away (direction flips up): door at 1+TRAVEL+1
        pulse(1'b0, 3);
        repeat (TRAVEL) step();
        check("s4_pre", 32'(door_open), 32'd0);
        step();
        check("s4_door", 32'(door_open), 32'd1);
        check("s4_floor", 32'(floor), 32'd3);
        repeat (DOOR) step();

        // Both sides at floor 3 going up: serve 6 then 1
        cab_req = 8'h40; hall_req = 8'h02;
        step();
        cab_req = '0; hall_req = '0;
        wait_door("s5_first", 3 * TRAVEL + 4);
        check("s5_floor6", 32'(floor), 32'd6);
        repeat (DOOR) step();
        wait_door("s5_second", 5 * TRAVEL + 4);
        check("s5_floor1", 32'(floor), 32'd1);
        repeat (DOOR) step();
        check("s5_empty", 32'(pending), 32'd0);

        // Top floor
        pulse(1'b0, 7);
        wait_door("s6_arrive", 6 * TRAVEL + 4);
        repeat (DOOR) step();
        pulse(1'b0, 7);
        check("s6_noup", 32'(engine), 32'd0);
        step();
        check("s6_door", 32'(door_open), 32'd1);
        check("s6_top", 32'(floor), 32'd7);
        repeat (DOOR) step();

        // Bottom floor
        pulse(1'b1, 0);
        wait_door("s7_arrive", 7 * TRAVEL + 4);
        repeat (DOOR) step();
        pulse(1'b1, 0);
        check("s7_nodown", 32'(engine), 32'd0);
        step();
        check("s7_door", 32'(door_open), 32'd1);
        check("s7_bottom", 32'(floor), 32'd0);
        repeat (DOOR) step();

        // Reset mid-travel
        pulse(1'b0, 7);
        repeat (TRAVEL + 3) step();
        check("s8_moving", 32'(engine), 32'd1);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_all();
        check("s8_rst_engine", 32'(engine), 32'd0);
        check("s8_rst_floor", 32'(floor), 32'd0);
        check("s8_rst_pending", 32'(pending), 32'd0);
        #2 RST = 1'b0;
        repeat (20) step();
        check("s8_idle_floor", 32'(floor), 32'd0);
        check("s8_idle_engine", 32'(engine), 32'd0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
`ifdef MGMT_LOCK_EN
            if (k % 300 == 0) begin
                send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
            end
`endif
            cab_req   = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom) & 8'($urandom)) : 8'h00;
            hall_req  = ($urandom_range(0, 5) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            bcd_valid = ($urandom_range(0, 39) == 0);
            bcd_digit = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 9));
            step();
        end
        cab_req = '0; hall_req = '0; bcd_valid = 1'b0;
        repeat (100) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
